// File: rtl/counter_arbiter_pkg.sv
// Shared types and default sizing for the round-robin countdown arbiter.
package counter_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module down_counter
    import counter_arbiter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting a shared down-counter to one requester at a time;
// the owner gets a one-cycle done pulse when its countdown ends or is aborted.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   req_init,
    input  logic                     abort,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt,
    output logic [N_REQ-1:0]         done,
    output logic                     aborted
);

    localparam int IDW = $clog2(N_REQ);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic [IDW-1:0]   gnt_id_q;
    logic [IDW-1:0]   last_id_q;
    logic             busy_q;
    logic             aborted_q;

    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic             any_req;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] win_init;

    // Walk from the farthest candidate back to last_id+1 so the nearest
    // requesting index is the one left in win_id.
    always_comb begin
        win_id = last_id_q;
        cand   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDW'((int'(last_id_q) + i) % N_REQ);
            if (req[cand]) begin
                win_id = cand;
            end
        end
    end

    assign any_req  = |req;
    assign win_init = req_init[int'(win_id)*CNT_W +: CNT_W];
    assign cnt_load = (state_q == IDLE) && any_req;
    assign cnt_dec  = (state_q == RUN) && !abort && !cnt_zero;

    down_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(win_init),
        .dec     (cnt_dec),
        .cnt     (cnt),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            gnt_id_q  <= '0;
            last_id_q <= IDW'(N_REQ - 1);
            busy_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= RUN;
                        gnt_q     <= N_REQ'(1) << win_id;
                        gnt_id_q  <= win_id;
                        last_id_q <= win_id;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort outranks reaching zero; the counter is held either way.
                    if (abort) begin
                        state_q   <= DONE;
                        gnt_q     <= '0;
                        done_q    <= N_REQ'(1) << gnt_id_q;
                        aborted_q <= 1'b1;
                    end else if (cnt_zero) begin
                        state_q   <= DONE;
                        gnt_q     <= '0;
                        done_q    <= N_REQ'(1) << gnt_id_q;
                        aborted_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= '0;
                    aborted_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the counter (2..16).
REQ-002 Parameter CNT_W, default 32, counter and init-value width.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  N_REQ  per-requester request level, bit i = requester i.
REQ-006 Port req_init  input  N_REQ*CNT_W  packed init values, slice i = [i*CNT_W +: CNT_W].
REQ-007 Port abort  input  1  terminate the current countdown early.
REQ-008 Port gnt  output  N_REQ  one-hot grant to the owning requester, all-zero when none.
REQ-009 Port gnt_id  output  $clog2(N_REQ)  index of current/last owner.
REQ-010 Port busy  output  1  high in RUN and DONE states.
REQ-011 Port cnt  output  CNT_W  current counter value.
REQ-012 Port done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-013 Port aborted  output  1  high together with done when the countdown ended via abort.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: req sampled every edge; if any bit set, winner chosen round-robin, cnt <= winner's req_init slice, gnt_id <= winner, gnt <= one-hot(winner), next RUN; else stay IDLE.
REQ-016 Round-robin search order SHALL start at last_id+1 modulo N_REQ and wrap; last_id updates to the winner on every grant.
REQ-017 RUN: cnt != 0 and abort low -> cnt decrements by 1, stay RUN.
REQ-018 RUN: cnt == 0 -> next DONE, gnt <= 0, done[gnt_id] <= 1, aborted <= 0.
REQ-019 RUN: abort high (any cnt) -> next DONE, gnt <= 0, done[gnt_id] <= 1, aborted <= 1, cnt held; abort has priority over cnt == 0.
REQ-020 DONE: lasts exactly one cycle, then IDLE with done <= 0, aborted <= 0; req ignored in DONE.
REQ-021 Latency for init value N without abort: grant at edge k, done high during cycle after edge k+N+1, IDLE after edge k+N+2.
REQ-022 req_init = 0 SHALL give one RUN cycle then DONE; cnt never underflows or wraps.
REQ-023 req, req_init and abort SHALL be ignored in states where not listed; changes to req_init during RUN have no effect.
REQ-024 Requester contract: drop req by the edge that ends its done cycle; a req still high in the following IDLE is a new request.
REQ-025 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-026 rst low SHALL immediately force state IDLE, gnt 0, done 0, aborted 0, busy 0, cnt 0, gnt_id 0, last_id N_REQ-1 (requester 0 wins first).
REQ-027 Reset asserted mid-RUN SHALL abandon the countdown without a done pulse; first arbitration occurs at the first edge after rst deasserts.

Structure
REQ-028 Package counter_arbiter_pkg SHALL hold the state enum typedef and default N_REQ/CNT_W constants.
REQ-029 Sub-module down_counter (load, load_val, dec, cnt, zero) SHALL implement the counter datapath; arbitration and FSM stay in counter_arbiter.

Verification
REQ-030 Single request: req=0001, init0=10 -> gnt=0001, cnt 10..0 over 11 cycles, done=0001 for one cycle, aborted=0.
REQ-031 Zero init: req=0100, init2=0 -> one RUN cycle (cnt=0), then done=0100.
REQ-032 Contention: req=1111 held, all inits=3 -> grant order 0,1,2,3,0 with one IDLE cycle between jobs.
REQ-033 Abort: init1=20, abort pulsed when cnt=15 -> next cycle done=0010, aborted=1, cnt=15.
REQ-034 Reset mid-RUN: init0=50, rst low at cnt=30 -> outputs at reset values immediately, no done pulse; req=0001 after release restarts at 50.
REQ-035 Max value: init=2^CNT_W-1 with abort after 5 cycles -> cnt = 2^CNT_W-6, no wrap.
